// File: rtl/gray_counter_conv.sv
// gray_counter_conv: up/down binary+Gray counter (wrap or saturate) with an
// independent 2-stage binary<->Gray converter pipeline.
`default_nettype none

module gray_counter_conv #(
   parameter int WIDTH = 4,
   parameter int WRAP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             load_is_gray,
   output logic [WIDTH-1:0] cnt_bin,
   output logic [WIDTH-1:0] cnt_gray,
   output logic             sat,
   output logic             wrap_pulse,
   input  logic [WIDTH-1:0] conv_in,
   input  logic             conv_in_valid,
   input  logic             conv_dir,
   output logic [WIDTH-1:0] conv_out,
   output logic             conv_out_valid
);

   localparam logic [WIDTH-1:0] c_max = '1;
   localparam logic [WIDTH-1:0] c_min = '0;

   function automatic logic [WIDTH-1:0] f_bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [WIDTH-1:0] f_gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_sat;
   logic             r_pulse;

   logic [WIDTH-1:0] w_next_bin;
   logic             w_next_sat;
   logic             w_next_pulse;
   logic             w_blocked;
   logic [WIDTH-1:0] w_stepped;

   always_comb begin
      w_next_bin   = r_bin;
      w_next_sat   = r_sat;
      w_next_pulse = 1'b0;
      w_blocked    = up ? (r_bin == c_max) : (r_bin == c_min);
      w_stepped    = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
      if (load) begin
         w_next_bin = load_is_gray ? f_gray2bin(load_val) : load_val;
         w_next_sat = 1'b0;
      end else if (en) begin
         if (!w_blocked) begin
            w_next_bin = w_stepped;
            w_next_sat = 1'b0;
         end else if (WRAP != 0) begin
            w_next_bin   = w_stepped;
            w_next_pulse = 1'b1;
         end else begin
            // Only the first blocked step pulses; repeated pushes into the limit stay quiet.
            w_next_sat   = 1'b1;
            w_next_pulse = ~r_sat;
         end
      end
   end

   // Gray is taken from the next binary value so both outputs change on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin   <= '0;
         r_gray  <= '0;
         r_sat   <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_bin   <= w_next_bin;
         r_gray  <= f_bin2gray(w_next_bin);
         r_sat   <= w_next_sat;
         r_pulse <= w_next_pulse;
      end
   end

   logic [WIDTH-1:0] r_s1_data;
   logic             r_s1_dir;
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s2_data;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_conv_out;
   logic             r_conv_valid;
   logic [WIDTH-1:0] w_conv;

   assign w_conv = r_s1_dir ? f_gray2bin(r_s1_data) : f_bin2gray(r_s1_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_data    <= '0;
         r_s1_dir     <= 1'b0;
         r_s1_valid   <= 1'b0;
         r_s2_data    <= '0;
         r_s2_valid   <= 1'b0;
         r_conv_out   <= '0;
         r_conv_valid <= 1'b0;
      end else begin
         r_s1_valid   <= conv_in_valid;
         r_s2_valid   <= r_s1_valid;
         r_conv_valid <= r_s2_valid;
         if (conv_in_valid) begin
            r_s1_data <= conv_in;
            r_s1_dir  <= conv_dir;
         end
         if (r_s1_valid) begin
            r_s2_data <= w_conv;
         end
         if (r_s2_valid) begin
            r_conv_out <= r_s2_data;
         end
      end
   end

   assign cnt_bin        = r_bin;
   assign cnt_gray       = r_gray;
   assign sat            = r_sat;
   assign wrap_pulse     = r_pulse;
   assign conv_out       = r_conv_out;
   assign conv_out_valid = r_conv_valid;

endmodule

`default_nettype wire

// File: tb/tb_gray_counter_conv.sv
// tb_gray_counter_conv: directed and random checks of gray_counter_conv in
// both wrap and saturate modes, with a queue scoreboard for the converter.
`default_nettype none

module tb_gray_counter_conv;

   logic       clk = 1'b0;
   logic       rst, en, up, load, load_is_gray, conv_in_valid, conv_dir;
   logic [3:0] load_val, conv_in;

   logic [3:0] w_bin, w_gray, w_cout;
   logic       w_sat, w_pulse, w_cvalid;
   logic [3:0] s_bin, s_gray, s_cout;
   logic       s_sat, s_pulse, s_cvalid;

   always #5 clk = ~clk;

   gray_counter_conv #(.WIDTH(4), .WRAP(1)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .load_is_gray(load_is_gray), .cnt_bin(w_bin), .cnt_gray(w_gray), .sat(w_sat),
      .wrap_pulse(w_pulse), .conv_in(conv_in), .conv_in_valid(conv_in_valid),
      .conv_dir(conv_dir), .conv_out(w_cout), .conv_out_valid(w_cvalid));

   gray_counter_conv #(.WIDTH(4), .WRAP(0)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .load_is_gray(load_is_gray), .cnt_bin(s_bin), .cnt_gray(s_gray), .sat(s_sat),
      .wrap_pulse(s_pulse), .conv_in(conv_in), .conv_in_valid(conv_in_valid),
      .conv_dir(conv_dir), .conv_out(s_cout), .conv_out_valid(s_cvalid));

   typedef struct {
      int         due;
      logic [3:0] val;
   } exp_t;
   exp_t q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mw = 0, ms = 0;
   bit ssat = 0, pw = 0, ps = 0, moved_w = 0, moved_s = 0;
   logic [3:0] prev_w, prev_s;

   function automatic logic [3:0] b2g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] g2b(input logic [3:0] g);
      return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int v;
      moved_w = 0;
      moved_s = 0;
      pw = 0;
      ps = 0;
      if (load) begin
         v    = load_is_gray ? int'(g2b(load_val)) : int'(load_val);
         mw   = v;
         ms   = v;
         ssat = 0;
      end else if (en) begin
         moved_w = 1;
         if (up) begin
            pw = (mw == 15);
            mw = (mw + 1) % 16;
            if (ms == 15) begin
               ps   = !ssat;
               ssat = 1;
            end else begin
               ms++;
               ssat    = 0;
               moved_s = 1;
            end
         end else begin
            pw = (mw == 0);
            mw = (mw + 15) % 16;
            if (ms == 0) begin
               ps   = !ssat;
               ssat = 1;
            end else begin
               ms--;
               ssat    = 0;
               moved_s = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("bin_wrap", w_bin, mw);
      chk("gray_wrap", w_gray, b2g(4'(mw)));
      chk("sat_wrap", w_sat, 0);
      chk("pulse_wrap", w_pulse, pw);
      chk("bin_sat", s_bin, ms);
      chk("gray_sat", s_gray, b2g(4'(ms)));
      chk("sat_sat", s_sat, ssat);
      chk("pulse_sat", s_pulse, ps);
      if (moved_w) chk("gray_1bit_wrap", $countones(prev_w ^ w_gray), 1);
      if (moved_s) chk("gray_1bit_sat", $countones(prev_s ^ s_gray), 1);
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("cvalid_wrap", w_cvalid, 1);
         chk("cout_wrap", w_cout, q[0].val);
         chk("cvalid_sat", s_cvalid, 1);
         chk("cout_sat", s_cout, q[0].val);
         void'(q.pop_front());
      end else begin
         chk("cvalid_idle_wrap", w_cvalid, 0);
         chk("cvalid_idle_sat", s_cvalid, 0);
      end
   endtask

   task automatic tick();
      model_step();
      if (conv_in_valid) q.push_back('{cyc + 3, conv_dir ? g2b(conv_in) : b2g(conv_in)});
      prev_w = w_gray;
      prev_s = s_gray;
      @(posedge clk);
      cyc++;
      #1;
      check_all();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_bin"}, {w_bin, s_bin}, 0);
      chk({tag, "_gray"}, {w_gray, s_gray}, 0);
      chk({tag, "_flags"}, {w_sat, w_pulse, s_sat, s_pulse}, 0);
      chk({tag, "_cout"}, {w_cout, s_cout}, 0);
      chk({tag, "_cvalid"}, {w_cvalid, s_cvalid}, 0);
   endtask

   logic [3:0] tbl [0:16];
   int         pulses;

   initial begin
      tbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      rst = 0; en = 0; up = 0; load = 0; load_val = 0; load_is_gray = 0;
      conv_in = 0; conv_in_valid = 0; conv_dir = 0;
      #1 rst = 1;
      #1 chk_zero("reset");
      @(posedge clk);
      #1;
      rst = 0;

      // wrap-mode Gray sequence over a full turn
      en = 1; up = 1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("seq_gray", w_gray, tbl[i]);
         chk("seq_pulse", w_pulse, (i == 16));
      end

      // saturate at max, then step back down
      en = 0; load = 1; load_val = 4'd14; load_is_gray = 0;
      tick();
      load = 0; en = 1; up = 1;
      pulses = 0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("satup_bin", s_bin, 15);
         chk("satup_flag", s_sat, (k >= 2));
         pulses += int'(s_pulse);
      end
      chk("satup_pulses", pulses, 1);
      up = 0;
      tick();
      chk("satdn_bin", s_bin, 14);
      chk("satdn_flag", s_sat, 0);

      // Gray load wins over a concurrent count enable
      load = 1; load_is_gray = 1; load_val = 4'b1100; en = 1; up = 1;
      tick();
      chk("gload_bin", {w_bin, s_bin}, {4'd8, 4'd8});
      chk("gload_gray", {w_gray, s_gray}, {4'b1100, 4'b1100});
      load = 0; load_is_gray = 0; en = 0;

      // converter back-to-back in both directions
      conv_in_valid = 1; conv_dir = 0; conv_in = 4'b1011;
      tick();
      conv_dir = 1; conv_in = 4'b1110;
      tick();
      conv_in_valid = 0;
      tick();
      chk("conv_b2g", {w_cvalid, w_cout}, {1'b1, 4'b1110});
      tick();
      chk("conv_g2b", {w_cvalid, w_cout}, {1'b1, 4'b1011});
      tick();
      chk("conv_hold", w_cout, 4'b1011);

      // asynchronous reset with count 9 and a sample in flight
      load = 1; load_val = 4'd9;
      tick();
      load = 0;
      conv_in_valid = 1; conv_dir = 0; conv_in = 4'd5;
      tick();
      conv_in_valid = 0;
      tick();
      chk("pre_rst_bin", w_bin, 9);
      #2 rst = 1;
      #1 chk_zero("async_rst");
      mw = 0; ms = 0; ssat = 0; pw = 0; ps = 0; moved_w = 0; moved_s = 0;
      q.delete();
      @(posedge clk);
      cyc++;
      #1;
      rst = 0;
      for (int k = 0; k < 4; k++) tick();
      chk("post_rst_cout", w_cout, 0);

      // random concurrent counter and converter traffic
      for (int n = 0; n < 10000; n++) begin
         en            = 1'($urandom_range(0, 3) != 0);
         up            = 1'($urandom_range(0, 1));
         load          = 1'($urandom_range(0, 15) == 0);
         load_val      = 4'($urandom_range(0, 15));
         load_is_gray  = 1'($urandom_range(0, 1));
         conv_in       = 4'($urandom_range(0, 15));
         conv_in_valid = 1'($urandom_range(0, 1));
         conv_dir      = 1'($urandom_range(0, 1));
         tick();
      end
      conv_in_valid = 0; en = 0; load = 0;
      for (int k = 0; k < 3; k++) tick();
      chk("queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gray_counter_conv.md
GRAY_COUNTER_CONV -- requirements
Module: gray_counter_conv

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the code width; legal range 2..32.
REQ-002 Parameter WRAP, default 1, SHALL select the counter mode: 1 = wrap-around, 0 = saturate.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 en  in  1  SHALL enable one count step per cycle.
REQ-006 up  in  1  SHALL set the count direction: 1 = increment, 0 = decrement.
REQ-007 load  in  1  SHALL request a synchronous load of load_val.
REQ-008 load_val  in  WIDTH  SHALL be the load value.
REQ-009 load_is_gray  in  1  SHALL mark load_val as Gray-coded (1) or binary (0).
REQ-010 cnt_bin  out  WIDTH  SHALL be the registered binary count.
REQ-011 cnt_gray  out  WIDTH  SHALL be the registered Gray encoding of the count.
REQ-012 sat  out  1  SHALL be the registered saturation flag; it is always 0 when WRAP=1.
REQ-013 wrap_pulse  out  1  SHALL be a registered one-cycle pulse marking a wrap or saturation event.
REQ-014 conv_in  in  WIDTH  SHALL be the data input to the converter pipeline.
REQ-015 conv_in_valid  in  1  SHALL qualify conv_in.
REQ-016 conv_dir  in  1  SHALL select the conversion: 0 = binary->Gray, 1 = Gray->binary.
REQ-017 conv_out  out  WIDTH  SHALL be the converter result.
REQ-018 conv_out_valid  out  1  SHALL qualify conv_out.

Function
REQ-019 Gray encoding SHALL be g = b XOR (b >> 1); Gray decoding SHALL be b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] XOR g[i].
REQ-020 cnt_gray SHALL be registered from the next binary value in the same edge as cnt_bin, so both outputs always describe the same count; no cycle of skew is permitted.
REQ-021 Priority SHALL be load > en > hold.
REQ-022 Load: on an edge with load=1, cnt_bin SHALL take load_val (decoded first when load_is_gray=1), sat SHALL clear, and wrap_pulse SHALL be 0.
REQ-023 Count with WRAP=1: the step SHALL be ±1 modulo 2^WIDTH; max->0 going up, or 0->max going down, SHALL set wrap_pulse=1 for exactly that cycle.
REQ-024 Count with WRAP=0: a step that would pass max (up) or 0 (down) SHALL leave the count unchanged, set sat=1, and pulse wrap_pulse once on the first blocked step only.
REQ-025 With sat=1, a step in the opposite direction SHALL move the count and clear sat; a further step in the blocked direction SHALL hold the count with no new pulse.
REQ-026 When en=0 and load=0 the count, sat and cnt_gray SHALL hold, and wrap_pulse SHALL be 0.
REQ-027 The converter SHALL be a 2-stage pipeline with fixed latency 2:
  - a sample accepted at edge N SHALL appear on conv_out and conv_out_valid at edge N+2;
  - the converter SHALL accept one sample per cycle with no stall;
  - conv_dir SHALL be captured together with conv_in.
REQ-028 While conv_out_valid=0, conv_out SHALL hold its last value.
REQ-029 The counter and the converter SHALL operate independently and concurrently.
REQ-030 Gray monotonicity: consecutive cnt_gray values produced by single count steps SHALL differ in exactly one bit, including across the wrap.

Reset
REQ-031 While rst=1 the block SHALL immediately, without waiting for a clock edge, drive cnt_bin=0, cnt_gray=0, sat=0, wrap_pulse=0, conv_out=0, conv_out_valid=0, and clear both pipeline-stage valids.
REQ-032 Reset asserted mid-operation SHALL discard in-flight converter samples; no conv_out_valid SHALL appear from data accepted before reset.
REQ-033 The first state update after rst deasserts SHALL occur on the first rising clk edge at which rst is low.

Verification (WIDTH=4)
REQ-034 WRAP=1, up=1, en=1 for 16 cycles from reset -> cnt_gray follows 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap_pulse=1 only on the 15->0 step.
REQ-035 WRAP=0, load binary 14, up=1, en=1 for 3 cycles -> cnt_bin 15,15,15; sat=1 from the second step; exactly one wrap_pulse; then up=0 for one step -> cnt_bin=14, sat=0.
REQ-036 load=1, load_is_gray=1, load_val=4'b1100, with en=1 in the same cycle -> cnt_bin=8, cnt_gray=4'b1100, no count step that cycle.
REQ-037 Converter back-to-back: (dir0, 4'b1011) then (dir1, 4'b1110) -> conv_out=4'b1110 at N+2 and 4'b1011 at N+3, with conv_out_valid high for both cycles.
REQ-038 Assert rst asynchronously between edges while the count is 9 and one converter sample is in flight -> outputs are 0 immediately, and no conv_out_valid follows reset release.
REQ-039 Random en/up/load stimulus for 10k cycles -> the scoreboard confirms REQ-020 and REQ-030 on every cycle.
